fp_div: RTL and testbench
=========================

FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have parameters: i1, 2, dividend integer bits.
REQ-002 SHALL have parameters: f1, 14, dividend fraction bits.
REQ-003 SHALL have parameters: i2, 2, divisor integer bits.
REQ-004 SHALL have parameters: f2, 14, divisor fraction bits.
REQ-005 SHALL have parameters: i3, 2, quotient integer bits.
REQ-006 SHALL have parameters: f3, 14, quotient fraction bits.
REQ-007 SHALL require f2+f3 >= f1; define WN = i1+f2+f3 (iteration count) and W3 = i3+f3.
REQ-008 clk  input  1  single clock, rising edge.
REQ-009 rst_n  input  1  reset, asynchronous, active-low.
REQ-010 in_valid  input  1  operands valid.
REQ-011 in_ready  output  1  block can accept operands.
REQ-012 a  input  i1+f1  dividend.
REQ-013 s1  input  1  1 = a is two's complement, 0 = unsigned.
REQ-014 b  input  i2+f2  divisor.
REQ-015 s2  input  1  1 = b is two's complement, 0 = unsigned.
REQ-016 out_valid  output  1  result valid.
REQ-017 out_ready  input  1  consumer takes result.
REQ-018 c  output  W3  quotient, f3 fraction bits.
REQ-019 sign  output  1  1 = c is two's complement (registered s1|s2 of accepted operation).
REQ-020 overflow  output  1  quotient saturated.
REQ-021 underflow  output  1  nonzero true quotient truncated to zero.
REQ-022 div_by_zero  output  1  divisor was zero.

Function
REQ-023 SHALL use FSM states IDLE, CALC, FIX, DONE; in_ready = 1 only in IDLE.
REQ-024 Acceptance edge (IDLE, in_valid=1): register |A|, |B|, s1, s2, and result negativity (neg = signed MSB of a XOR signed MSB of b, counting only operands whose s flag is 1); next state CALC, or FIX when B = 0.
REQ-025 Numerator N = |A| << (f2+f3-f1), WN bits; unsigned restoring division, one quotient bit per cycle, MSB first, for exactly WN CALC cycles; then FIX.
REQ-026 Magnitude quotient Q = floor(N/|B|) (truncate toward zero); remainder R kept.
REQ-027 In FIX, one cycle, register the outputs and go to DONE, with out_valid=1 visible after that edge.
REQ-028 Latency: out_valid rises WN+1 edges after acceptance (31 at defaults); for B = 0, 1 edge after acceptance.
REQ-029 Unsigned (s1=s2=0): overflow = Q > 2^W3-1; saturate c to all ones.
REQ-030 Signed: overflow = Q > 2^(W3-1)-1 when neg=0, Q > 2^(W3-1) when neg=1; saturate c to 0111..1 or 1000..0 respectively; otherwise c = neg ? -Q : Q (W3 bits).
REQ-031 underflow = (Q = 0) and (R != 0); c = 0 in that case (no negative zero).
REQ-032 B = 0: div_by_zero=1, overflow=1, underflow=0, c saturated per REQ-029/030 with neg taken as sign of a (a = 0 gives positive saturation).
REQ-033 DONE: c, sign and flags held stable while out_valid=1 and out_ready=0; the edge with out_ready=1 clears out_valid and goes to IDLE.
REQ-034 in_valid while not in IDLE SHALL be ignored; operand changes after acceptance SHALL NOT affect the result.
REQ-035 c, sign and flags SHALL hold their last value until the next FIX.

Reset
REQ-036 rst_n=0 SHALL, asynchronously and at any state including mid-CALC, force IDLE, in_ready=1, out_valid=0, and c, sign, overflow, underflow, div_by_zero and internal registers to 0.
REQ-037 The in-flight operation SHALL be discarded; the first post-reset acceptance SHALL behave as from power-up.

Verification (defaults 2.14)
REQ-038 a=0x4000, b=0x2000, s1=s2=0 -> c=0x8000, all flags 0, sign=0, out_valid 31 edges after accept.
REQ-039 a=0xC000 s1=1, b=0x2000 s2=0 -> c=0x8000 (-2.0 exact), sign=1, overflow=0, underflow=0.
REQ-040 a=0xC000, b=0x2000 unsigned -> c=0xFFFF, overflow=1; same operands with s1=1,s2=1 and b=0xE000 (-0.5) -> c=0x7FFF (+2.0 saturated), overflow=1.
REQ-041 a=0x0001, b=0xC000 unsigned -> c=0x0000, underflow=1, overflow=0.
REQ-042 b=0x0000, a=0x1234 unsigned -> div_by_zero=1, overflow=1, c=0xFFFF, out_valid 1 edge after accept; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0.
REQ-043 rst_n pulsed low 10 cycles into CALC -> out_valid=0, in_ready=1 immediately; the next operation (REQ-038 operands) -> c=0x8000 at the full 31-edge latency.

Source files
------------

// File: rtl/fp_div_if.sv
// rtl/fp_div_if.sv - operand/result handshake bundle for the fixed-point divider
interface fp_div_if #(
  parameter int W1 = 16,
  parameter int W2 = 16,
  parameter int W3 = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [W1-1:0] a;
  logic          s1;
  logic [W2-1:0] b;
  logic          s2;
  logic          out_valid;
  logic          out_ready;
  logic [W3-1:0] c;
  logic          sign;
  logic          overflow;
  logic          underflow;
  logic          div_by_zero;

  // operand producer / result consumer side
  modport master (
    output in_valid, a, s1, b, s2, out_ready,
    input  in_ready, out_valid, c, sign, overflow, underflow, div_by_zero
  );

  // divider side
  modport slave (
    input  in_valid, a, s1, b, s2, out_ready,
    output in_ready, out_valid, c, sign, overflow, underflow, div_by_zero
  );
endinterface

// File: rtl/fp_div.sv
// rtl/fp_div.sv - multi-cycle restoring fixed-point divider with saturation flags
module fp_div #(
  parameter int i1 = 2,
  parameter int f1 = 14,
  parameter int i2 = 2,
  parameter int f2 = 14,
  parameter int i3 = 2,
  parameter int f3 = 14
) (
  input  logic      clk,
  input  logic      rst_n,
  fp_div_if.slave   bus
);
  // f2+f3 >= f1 is assumed so the dividend only ever shifts left
  localparam int W1 = i1 + f1;
  localparam int W2 = i2 + f2;
  localparam int W3 = i3 + f3;
  localparam int WN = i1 + f2 + f3;
  localparam int CW = $clog2(WN + 1);
  localparam int WQ = WN + W3 + 1;

  localparam logic [WQ-1:0] MAX_U   = {{(WQ-W3){1'b0}}, {W3{1'b1}}};
  localparam logic [WQ-1:0] MAX_POS = {{(WQ-W3+1){1'b0}}, {(W3-1){1'b1}}};
  localparam logic [WQ-1:0] MAX_NEG = {{(WQ-W3){1'b0}}, 1'b1, {(W3-1){1'b0}}};
  localparam logic [W3-1:0] SAT_U   = {W3{1'b1}};
  localparam logic [W3-1:0] SAT_P   = {1'b0, {(W3-1){1'b1}}};
  localparam logic [W3-1:0] SAT_N   = {1'b1, {(W3-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state_q, state_d;

  logic [WN-1:0] n_q;       // dividend shifts out MSB-first, quotient bits shift in
  logic [W2-1:0] r_q;
  logic [W2-1:0] b_q;
  logic [CW-1:0] cnt_q;
  logic          s1_q, s2_q, neg_q, bz_q;
  logic [W3-1:0] c_q;
  logic          sign_q, ovf_q, unf_q, dbz_q;

  // operand conditioning at the acceptance edge
  logic          a_neg, b_neg, b_zero;
  logic [W1-1:0] a_mag;
  logic [W2-1:0] b_mag;
  logic [WN-1:0] n_init;
  assign a_neg  = bus.s1 & bus.a[W1-1];
  assign b_neg  = bus.s2 & bus.b[W2-1];
  assign a_mag  = a_neg ? -bus.a : bus.a;
  assign b_mag  = b_neg ? -bus.b : bus.b;
  assign b_zero = (bus.b == '0);
  assign n_init = WN'(a_mag) << (f2 + f3 - f1);

  // one restoring step: trial-subtract the divisor from the shifted remainder
  logic [W2:0]   r_shift, r_sub;
  logic          ge;
  assign r_shift = {r_q, n_q[WN-1]};
  assign ge      = (r_shift >= {1'b0, b_q});
  assign r_sub   = r_shift - {1'b0, b_q};

  // result formatting; with B = 0 neg_q already equals the sign of a
  logic [WQ-1:0] q_ext;
  logic          signed_op;
  logic [W3-1:0] c_fix;
  logic          ovf_fix, unf_fix;
  assign q_ext     = WQ'(n_q);
  assign signed_op = s1_q | s2_q;

  // saturation, truncation-to-zero and sign application
  always_comb begin
    ovf_fix = 1'b0;
    unf_fix = 1'b0;
    c_fix   = '0;
    if (bz_q)
      ovf_fix = 1'b1;
    else if (!signed_op)
      ovf_fix = (q_ext > MAX_U);
    else
      ovf_fix = neg_q ? (q_ext > MAX_NEG) : (q_ext > MAX_POS);
    unf_fix = !bz_q && (n_q == '0) && (r_q != '0);
    if (ovf_fix)
      c_fix = !signed_op ? SAT_U : (neg_q ? SAT_N : SAT_P);
    else if (neg_q)
      c_fix = -q_ext[W3-1:0];
    else
      c_fix = q_ext[W3-1:0];
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = b_zero ? FIX : CALC;
      CALC: if (cnt_q == CW'(WN - 1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  // datapath: capture operands, iterate, then latch the formatted result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= '0; r_q <= '0; b_q <= '0; cnt_q <= '0;
      s1_q <= 1'b0; s2_q <= 1'b0; neg_q <= 1'b0; bz_q <= 1'b0;
      c_q <= '0; sign_q <= 1'b0; ovf_q <= 1'b0; unf_q <= 1'b0; dbz_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          n_q   <= n_init;
          r_q   <= '0;
          b_q   <= b_mag;
          cnt_q <= '0;
          s1_q  <= bus.s1;
          s2_q  <= bus.s2;
          neg_q <= a_neg ^ b_neg;
          bz_q  <= b_zero;
        end
        CALC: begin
          n_q   <= {n_q[WN-2:0], ge};
          r_q   <= ge ? r_sub[W2-1:0] : r_shift[W2-1:0];
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          c_q    <= c_fix;
          sign_q <= signed_op;
          ovf_q  <= ovf_fix;
          unf_q  <= unf_fix;
          dbz_q  <= bz_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.c           = c_q;
  assign bus.sign        = sign_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_fp_div.sv
// tb/tb_fp_div.sv - directed self-checking bench for fp_div at 2.14 formats
module tb_fp_div;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fp_div_if #(.W1(16), .W2(16), .W3(16)) bus ();

  fp_div #(.i1(2), .f1(14), .i2(2), .f2(14), .i3(2), .f3(14)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic s1v,
                        input logic [15:0] bv, input logic s2v, input int exp_lat,
                        input logic [15:0] exp_c, input logic exp_sign,
                        input logic exp_ovf, input logic exp_unf, input logic exp_dbz);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready_idle"}, bus.in_ready, 1);
    bus.a = av; bus.s1 = s1v; bus.b = bv; bus.s2 = s2v; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = ~av; bus.b = 16'h0001; bus.s1 = ~s1v; bus.s2 = ~s2v;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      if (lat == 3) bus.in_valid = 1'b1;
      if (lat == 6) bus.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".in_ready_done"}, bus.in_ready, 0);
    check({tag, ".c"}, bus.c, exp_c);
    check({tag, ".sign"}, bus.sign, exp_sign);
    check({tag, ".overflow"}, bus.overflow, exp_ovf);
    check({tag, ".underflow"}, bus.underflow, exp_unf);
    check({tag, ".div_by_zero"}, bus.div_by_zero, exp_dbz);
  endtask

  task automatic consume(input string tag, input logic [15:0] exp_c);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, ".out_valid_cleared"}, bus.out_valid, 0);
    check({tag, ".in_ready_back"}, bus.in_ready, 1);
    check({tag, ".c_held"}, bus.c, exp_c);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.s1 = 1'b0; bus.s2 = 1'b0;
    #12;
    check("reset.in_ready", bus.in_ready, 1);
    check("reset.out_valid", bus.out_valid, 0);
    check("reset.c", bus.c, 0);
    check("reset.flags", {bus.sign, bus.overflow, bus.underflow, bus.div_by_zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.0 / 0.5 unsigned = 2.0
    run_op("u_2p0", 16'h4000, 0, 16'h2000, 0, 31, 16'h8000, 0, 0, 0, 0);
    consume("u_2p0", 16'h8000);
    // -1.0 / 0.5 = -2.0, exactly the most negative code
    run_op("s_m2p0", 16'hC000, 1, 16'h2000, 0, 31, 16'h8000, 1, 0, 0, 0);
    consume("s_m2p0", 16'h8000);
    // 3.0 / 0.5 unsigned = 6.0 saturates
    run_op("u_ovf", 16'hC000, 0, 16'h2000, 0, 31, 16'hFFFF, 0, 1, 0, 0);
    consume("u_ovf", 16'hFFFF);
    // -1.0 / -0.5 = +2.0 saturates positive
    run_op("s_ovf", 16'hC000, 1, 16'hE000, 1, 31, 16'h7FFF, 1, 1, 0, 0);
    consume("s_ovf", 16'h7FFF);
    // 2^-14 / 3.0 truncates to zero
    run_op("u_unf", 16'h0001, 0, 16'hC000, 0, 31, 16'h0000, 0, 0, 1, 0);
    consume("u_unf", 16'h0000);
    // 1.5 / 2.0 = 0.75
    run_op("u_0p75", 16'h6000, 0, 16'h8000, 0, 31, 16'h3000, 0, 0, 0, 0);
    consume("u_0p75", 16'h3000);
    // 1.0 / -1.5: |Q| = floor(2^28/24576) = 0x2AAA, negated -> 0xD556
    run_op("s_trunc", 16'h4000, 0, 16'hA000, 1, 31, 16'hD556, 1, 0, 0, 0);
    consume("s_trunc", 16'hD556);

    // divide by zero, then hold the result against a stalled consumer
    run_op("dbz_u", 16'h1234, 0, 16'h0000, 0, 1, 16'hFFFF, 0, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("dbz_hold.out_valid", bus.out_valid, 1);
      check("dbz_hold.in_ready", bus.in_ready, 0);
      check("dbz_hold.c", bus.c, 16'hFFFF);
      check("dbz_hold.flags", {bus.overflow, bus.div_by_zero}, 2'b11);
    end
    consume("dbz_u", 16'hFFFF);
    // signed negative dividend over zero saturates negative; zero over zero positive
    run_op("dbz_sneg", 16'hC000, 1, 16'h0000, 1, 1, 16'h8000, 1, 1, 0, 1);
    consume("dbz_sneg", 16'h8000);
    run_op("dbz_szero", 16'h0000, 1, 16'h0000, 0, 1, 16'h7FFF, 1, 1, 0, 1);
    consume("dbz_szero", 16'h7FFF);

    // reset mid-CALC discards the operation
    @(negedge clk);
    bus.a = 16'hC000; bus.s1 = 1'b0; bus.b = 16'h2000; bus.s2 = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset.out_valid", bus.out_valid, 0);
    check("midreset.in_ready", bus.in_ready, 1);
    check("midreset.c", bus.c, 0);
    check("midreset.sign", bus.sign, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_reset", 16'h4000, 0, 16'h2000, 0, 31, 16'h8000, 0, 0, 0, 0);
    consume("post_reset", 16'h8000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
